// File: rtl/i2s_rx_if.sv
// Sample bus out of the I2S receiver: one stereo pair plus status strobes,
// all in the system clock domain.
interface i2s_rx_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] left_out;
    logic signed [DATA_W-1:0] right_out;
    logic                     sample_valid;
    logic                     frame_err;

    modport master (
        output left_out,
        output right_out,
        output sample_valid,
        output frame_err
    );

    modport slave (
        input left_out,
        input right_out,
        input sample_valid,
        input frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver for the codec ADC path.
// The serial side runs on rising bclk and deserialises MSB-first words with
// the standard one-bit delay after each lrclk transition. Completed stereo
// pairs and truncation events cross into clk through toggle synchronisers.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_UNLOCKED | after reset, waiting for the first lrclk transition
// ST_LOCKED   | word boundaries known, capturing channel words
module i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_bclk,
    input  logic     i_lrclk,
    input  logic     i_adcdat,
    i2s_rx_if.master o_bus
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // bclk domain
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_lr_q;
    logic              r_chan;
    logic              w_chan_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-2:0] w_shift_nxt;
    logic [DATA_W-1:0] r_l_hold;
    logic [DATA_W-1:0] w_l_hold_nxt;
    logic              r_have_left;
    logic              w_have_left_nxt;
    logic [DATA_W-1:0] r_pair_l;
    logic [DATA_W-1:0] w_pair_l_nxt;
    logic [DATA_W-1:0] r_pair_r;
    logic [DATA_W-1:0] w_pair_r_nxt;
    logic              r_req_tgl;
    logic              w_req_tgl_nxt;
    logic              r_err_tgl;
    logic              w_err_tgl_nxt;
    logic              w_lr_edge;
    logic [DATA_W-1:0] w_word;

    // clk domain
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_err_sync;
    logic                   r_req_d;
    logic                   r_err_d;
    logic                   w_req_pulse;
    logic                   w_err_pulse;
    logic [DATA_W-1:0]      r_left_out;
    logic [DATA_W-1:0]      r_right_out;
    logic                   r_sample_valid;
    logic                   r_frame_err;

    assign w_lr_edge = (i_lrclk != r_lr_q);
    assign w_word    = {r_shift, i_adcdat};

    // bclk-domain state register: lock FSM, deserialiser and handoff registers
    always_ff @(posedge i_bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_UNLOCKED;
            r_lr_q      <= 1'b0;
            r_chan      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_l_hold    <= '0;
            r_have_left <= 1'b0;
            r_pair_l    <= '0;
            r_pair_r    <= '0;
            r_req_tgl   <= 1'b0;
            r_err_tgl   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lr_q      <= i_lrclk;
            r_chan      <= w_chan_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_l_hold    <= w_l_hold_nxt;
            r_have_left <= w_have_left_nxt;
            r_pair_l    <= w_pair_l_nxt;
            r_pair_r    <= w_pair_r_nxt;
            r_req_tgl   <= w_req_tgl_nxt;
            r_err_tgl   <= w_err_tgl_nxt;
        end
    end

    // Next-state: an lrclk transition starts a new word (the bit on that edge is
    // the previous slot's tail); otherwise shift until DATA_W bits, then hold.
    always_comb begin
        w_state_nxt     = r_state;
        w_chan_nxt      = r_chan;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_l_hold_nxt    = r_l_hold;
        w_have_left_nxt = r_have_left;
        w_pair_l_nxt    = r_pair_l;
        w_pair_r_nxt    = r_pair_r;
        w_req_tgl_nxt   = r_req_tgl;
        w_err_tgl_nxt   = r_err_tgl;

        if (w_lr_edge) begin
            w_state_nxt   = ST_LOCKED;
            w_chan_nxt    = i_lrclk;
            w_bit_cnt_nxt = '0;
            if ((r_state == ST_LOCKED) && (r_bit_cnt < CNT_FULL)) begin
                w_err_tgl_nxt = ~r_err_tgl;
                // A cut-short left word must not pair with the next right word.
                if (!r_chan) begin
                    w_have_left_nxt = 1'b0;
                end
            end
        end else if ((r_state == ST_LOCKED) && (r_bit_cnt < CNT_FULL)) begin
            w_shift_nxt   = w_word[DATA_W-2:0];
            w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
            if (r_bit_cnt == CNT_LAST) begin
                if (!r_chan) begin
                    w_l_hold_nxt    = w_word;
                    w_have_left_nxt = 1'b1;
                end else if (r_have_left) begin
                    w_pair_l_nxt    = r_l_hold;
                    w_pair_r_nxt    = w_word;
                    w_req_tgl_nxt   = ~r_req_tgl;
                    w_have_left_nxt = 1'b0;
                end
            end
        end
    end

    // Toggle synchronisers plus edge-detect flops into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_sync <= '0;
            r_err_sync <= '0;
            r_req_d    <= 1'b0;
            r_err_d    <= 1'b0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
            r_err_sync <= {r_err_sync[SYNC_STAGES-2:0], r_err_tgl};
            r_req_d    <= r_req_sync[SYNC_STAGES-1];
            r_err_d    <= r_err_sync[SYNC_STAGES-1];
        end
    end

    assign w_req_pulse = r_req_sync[SYNC_STAGES-1] ^ r_req_d;
    assign w_err_pulse = r_err_sync[SYNC_STAGES-1] ^ r_err_d;

    // Output registers: pair_l/pair_r are quiet for a whole word after the
    // toggle, so they are safe to sample when the synchronised edge arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_out     <= '0;
            r_right_out    <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= w_req_pulse;
            r_frame_err    <= w_err_pulse;
            if (w_req_pulse) begin
                r_left_out  <= r_pair_l;
                r_right_out <= r_pair_r;
            end
        end
    end

    assign o_bus.left_out     = r_left_out;
    assign o_bus.right_out    = r_right_out;
    assign o_bus.sample_valid = r_sample_valid;
    assign o_bus.frame_err    = r_frame_err;
endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames on bclk/lrclk/adcdat, predicts the
// delivered stereo pairs and truncation errors with a word-level model, and
// compares against the sample bus through a scoreboard queue.
module tb_i2s_rx;
    localparam int DW    = 16;
    localparam int BHALF = 163;   // ~3.07 MHz bclk

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bclk  = 1'b0;
    logic lrclk = 1'b0;
    logic adcdat = 1'b0;

    i2s_rx_if #(.DATA_W(DW)) bus ();

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bclk   (bclk),
        .i_lrclk  (lrclk),
        .i_adcdat (adcdat),
        .o_bus    (bus)
    );

    always #10 clk = ~clk;   // 50 MHz

    int n_checks  = 0;
    int n_fail    = 0;
    int obs_pairs = 0;
    int obs_err   = 0;
    int exp_err   = 0;

    logic [31:0] sb_q[$];

    // word-level model of the receiver
    logic        m_lr_q      = 1'b0;
    bit          m_locked    = 1'b0;
    logic        m_chan      = 1'b0;
    int          m_cnt       = 0;
    bit          m_have_left = 1'b0;
    logic [15:0] m_lhold     = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_lr_q      = 1'b0;
        m_locked    = 1'b0;
        m_chan      = 1'b0;
        m_cnt       = 0;
        m_have_left = 1'b0;
    endtask

    task automatic model_half(input logic lr, input logic [15:0] word, input int nslots);
        if (lr != m_lr_q) begin
            if (m_locked && m_cnt < DW) begin
                exp_err++;
                if (!m_chan) m_have_left = 1'b0;
            end
            m_locked = 1'b1;
            m_chan   = lr;
            m_cnt    = (nslots - 1 >= DW) ? DW : nslots - 1;
            if (nslots - 1 >= DW) begin
                if (!lr) begin
                    m_lhold     = word;
                    m_have_left = 1'b1;
                end else if (m_have_left) begin
                    sb_q.push_back({m_lhold, word});
                    m_have_left = 1'b0;
                end
            end
        end
        m_lr_q = lr;
    endtask

    // One channel slot: bit 0 is the previous slot's tail, bits 1..DW carry the word MSB first.
    task automatic send_half(input logic lr, input logic [15:0] word, input int nslots,
                             input logic pad, input bit model_en);
        if (model_en) model_half(lr, word, nslots);
        for (int k = 0; k < nslots; k++) begin
            bclk   = 1'b0;
            lrclk  = lr;
            adcdat = (k >= 1 && k <= DW) ? word[DW-k] : pad;
            #BHALF;
            bclk = 1'b1;
            #BHALF;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nl, input int nr, input logic pad);
        send_half(1'b0, l, nl, pad, 1'b1);
        send_half(1'b1, r, nr, pad, 1'b1);
    endtask

    task automatic end_test(input string tag, input int base_pairs, input int n_exp);
        repeat (10) @(posedge clk);
        chk({tag, "_pulses"}, obs_pairs - base_pairs, n_exp);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
        chk({tag, "_errs"}, obs_err, exp_err);
    endtask

    // Monitor: sampled on the falling clk edge, away from output updates
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.sample_valid) begin
                    obs_pairs++;
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("left_out",  {16'h0, bus.left_out},  {16'h0, e[31:16]});
                        chk("right_out", {16'h0, bus.right_out}, {16'h0, e[15:0]});
                    end else begin
                        chk("spurious_valid", {31'h0, bus.sample_valid}, 32'h0);
                    end
                end
                if (bus.frame_err) obs_err++;
            end
        end
    end

    initial begin
        int base;
        int ebase;

        repeat (5) @(posedge clk);
        chk("rst_left",  {16'h0, bus.left_out},  32'h0);
        chk("rst_right", {16'h0, bus.right_out}, 32'h0);
        chk("rst_valid", {31'h0, bus.sample_valid}, 32'h0);
        chk("rst_err",   {31'h0, bus.frame_err},    32'h0);
        rst_n = 1'b1;
        model_reset();

        // 1: 64-bclk frames; the first frame only establishes lock
        base = obs_pairs;
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        end_test("t1", base, 1);
        chk("t1_left_hold", {16'h0, bus.left_out}, 32'h0000_1234);

        // 2: 65-bclk frames, asymmetric halves, extreme values
        base = obs_pairs;
        for (int f = 0; f < 4; f++) send_frame(16'h8000, 16'h7FFF, 33, 32, 1'b0);
        end_test("t2", base, 4);

        // 3: reset asserted at the start of a right slot, released mid-slot
        base = obs_pairs;
        send_half(1'b0, 16'h1111, 32, 1'b0, 1'b1);
        rst_n = 1'b0;
        send_half(1'b1, 16'h2222, 12, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
        send_half(1'b1, 16'h3333, 20, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        chk("t3_no_early_pulse", obs_pairs - base, 0);
        send_frame(16'hCAFE, 16'h5A5A, 32, 32, 1'b0);
        end_test("t3", base, 1);

        // 4: left slot cut to 10 bclk, then a full frame
        base  = obs_pairs;
        ebase = obs_err;
        send_frame(16'hDEAD, 16'hBEEF, 10, 32, 1'b0);
        repeat (10) @(posedge clk);
        chk("t4_err_pulse", obs_err - ebase, 1);
        chk("t4_no_valid", obs_pairs - base, 0);
        send_frame(16'h0F0F, 16'hF0F0, 32, 32, 1'b0);
        end_test("t4", base, 1);

        // 5: padding bits set to 1 after the data word
        base = obs_pairs;
        send_frame(16'h00FF, 16'h0001, 32, 32, 1'b1);
        end_test("t5", base, 1);
        chk("t5_left_hold", {16'h0, bus.left_out}, 32'h0000_00FF);

        // 6: random data, random slot lengths down to the minimum DW+1
        base = obs_pairs;
        for (int f = 0; f < 50; f++) begin
            send_frame(16'($urandom), 16'($urandom), $urandom_range(DW + 1, 24),
                       $urandom_range(DW + 1, 24), 1'($urandom));
        end
        end_test("t6", base, 50);

        // bclk stopped: outputs hold, no pulses
        base = obs_pairs;
        repeat (100) @(posedge clk);
        chk("idle_no_pulse", obs_pairs - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
